// File: rtl/pool2d_stream_if.sv
// pool2d_stream_if: input/output stream handshakes, pooling mode and busy flag of pool2d_stream.
interface pool2d_stream_if #(
    parameter int CHANNELS = 1,
    parameter int DATA_W   = 16
);
    logic                       mode;
    logic                       in_valid;
    logic                       in_ready;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       out_last;
    logic                       busy;
    modport master (output mode, in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_last, busy);
    modport slave  (input  mode, in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_last, busy);
endinterface

// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming non-overlapping max/average 2-D pooling of a raster-scanned feature map.
module pool2d_stream #(
    parameter int CHANNELS     = 1,
    parameter int DATA_W       = 16,
    parameter int IMAGE_HEIGHT = 4,
    parameter int IMAGE_WIDTH  = 4,
    parameter int POOL_H       = 2,
    parameter int POOL_W       = 2
) (
    input logic          clock,
    input logic          reset_n,
    pool2d_stream_if.slave s
);
    localparam int SH        = $clog2(POOL_H * POOL_W);
    localparam int ACC_W     = DATA_W + SH;
    localparam int OUT_WIDTH = IMAGE_WIDTH / POOL_W;
    localparam int RW        = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW        = IMAGE_WIDTH > 1 ? $clog2(IMAGE_WIDTH) : 1;
    localparam int OW        = OUT_WIDTH > 1 ? $clog2(OUT_WIDTH) : 1;

    if (POOL_H < 1 || (POOL_H & (POOL_H - 1)) != 0 || IMAGE_HEIGHT % POOL_H != 0 ||
        POOL_W < 1 || (POOL_W & (POOL_W - 1)) != 0 || IMAGE_WIDTH % POOL_W != 0) begin : g_bad_pool
        $fatal(1, "pool2d_stream: POOL_H/POOL_W must be powers of two dividing the image");
    end

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                     state_q;
    logic [RW-1:0]              row_q;
    logic [CW-1:0]              col_q;
    logic                       mode_q, en_q, busy_q, out_valid_q, out_last_q;
    logic [CHANNELS*DATA_W-1:0] out_data_q;
    logic signed [ACC_W-1:0]    acc_q [OUT_WIDTH][CHANNELS];
    logic signed [ACC_W-1:0]    px_d  [CHANNELS];
    logic signed [ACC_W-1:0]    acc_d [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] res_d;
    logic                       accept, row_last, col_last, frame_first, frame_last;
    logic                       win_first, win_done, mode_d;
    logic [OW-1:0]              idx;

    assign s.in_ready   = en_q && state_q != DRAIN && (!out_valid_q || s.out_ready);
    assign s.out_valid  = out_valid_q;
    assign s.out_data   = out_data_q;
    assign s.out_last   = out_last_q;
    assign s.busy       = busy_q;
    assign accept       = s.in_valid && s.in_ready;
    assign row_last     = int'(row_q) == IMAGE_HEIGHT - 1;
    assign col_last     = int'(col_q) == IMAGE_WIDTH - 1;
    assign frame_first  = row_q == '0 && col_q == '0;
    assign frame_last   = row_last && col_last;
    assign win_first    = int'(row_q) % POOL_H == 0 && int'(col_q) % POOL_W == 0;
    assign win_done     = int'(row_q) % POOL_H == POOL_H - 1 && int'(col_q) % POOL_W == POOL_W - 1;
    assign mode_d       = frame_first ? s.mode : mode_q;
    assign idx          = OW'(int'(col_q) / POOL_W);

    // Max values are kept sign-extended so the full-width compare equals a DATA_W signed compare.
    always_comb begin
        px_d  = '{default: '0};
        acc_d = '{default: '0};
        res_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            px_d[c]  = ACC_W'(signed'(s.in_data[c*DATA_W +: DATA_W]));
            acc_d[c] = win_first ? px_d[c]
                     : mode_d ? acc_q[idx][c] + px_d[c]
                     : (px_d[c] > acc_q[idx][c] ? px_d[c] : acc_q[idx][c]);
            res_d[c*DATA_W +: DATA_W] = mode_d ? DATA_W'(acc_d[c] >>> SH) : acc_d[c][DATA_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (accept) acc_q[idx] <= acc_d;
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            mode_q      <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            en_q <= 1'b1;
            if (accept) begin
                col_q <= col_last ? '0 : col_q + 1'b1;
                if (col_last) row_q <= row_last ? '0 : row_q + 1'b1;
                if (frame_first) mode_q <= s.mode;
            end
            if (accept && win_done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_d;
                out_last_q  <= frame_last;
            end else if (s.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (state_q == IDLE && accept) begin
                state_q <= frame_last ? DRAIN : FILL;
                busy_q  <= 1'b1;
            end else if (state_q == FILL && accept && frame_last) begin
                state_q <= DRAIN;
            end else if (state_q == DRAIN && out_valid_q && out_last_q && s.out_ready) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream: random-stimulus bench for pool2d_stream against a window-level pooling model.
module tb_pool2d_stream;
    localparam int C = 2, W = 16, H = 4, IW = 4, PH = 2, PW = 2;

    typedef struct {
        int d0;
        int d1;
        bit last;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pool2d_stream_if #(.CHANNELS(C), .DATA_W(W)) tb_if ();

    pool2d_stream #(
        .CHANNELS(C), .DATA_W(W), .IMAGE_HEIGHT(H), .IMAGE_WIDTH(IW), .POOL_H(PH), .POOL_W(PW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .s      (tb_if.slave)
    );

    int   base [H][IW] = '{'{8, 1, 5, 3}, '{6, 7, 2, 4}, '{9, 0, 3, 2}, '{1, 5, 6, 8}};
    int   img [C][H][IW];
    exp_t exp_q [$];
    int   n_chk = 0, n_pass = 0;
    bit   bp = 1'b0, rdy_fix = 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int fdiv(input int s, input int d);
        return s >= 0 ? s / d : -((-s + d - 1) / d);
    endfunction

    // Reference: pool each window directly from the stored image.
    function automatic void model(input int m);
        for (int orow = 0; orow < H / PH; orow++)
            for (int ocol = 0; ocol < IW / PW; ocol++) begin
                exp_t e;
                for (int c = 0; c < C; c++) begin
                    int mx, sum, v, val;
                    mx  = img[c][orow*PH][ocol*PW];
                    sum = 0;
                    for (int dr = 0; dr < PH; dr++)
                        for (int dc = 0; dc < PW; dc++) begin
                            v = img[c][orow*PH+dr][ocol*PW+dc];
                            sum += v;
                            if (v > mx) mx = v;
                        end
                    val = m != 0 ? fdiv(sum, PH * PW) : mx;
                    if (c == 0) e.d0 = val;
                    else e.d1 = val;
                end
                e.last = orow == H / PH - 1 && ocol == IW / PW - 1;
                exp_q.push_back(e);
            end
    endfunction

    task automatic set_base();
        for (int r = 0; r < H; r++)
            for (int x = 0; x < IW; x++) begin
                img[0][r][x] = base[r][x];
                img[1][r][x] = -base[r][x];
            end
    endtask

    task automatic rand_img();
        for (int c = 0; c < C; c++)
            for (int r = 0; r < H; r++)
                for (int x = 0; x < IW; x++) img[c][r][x] = int'(signed'(16'($urandom)));
    endtask

    task automatic send_pixels(input int m, input int n, input bit rv);
        for (int p = 0; p < n; p++) begin
            int r, x, guard;
            bit took;
            r = p / IW;
            x = p % IW;
            if (rv) while ($urandom_range(0, 2) == 0) begin
                @(posedge clock);
                #1;
            end
            tb_if.in_valid = 1'b1;
            tb_if.mode     = p == 0 ? m[0] : 1'($urandom);
            tb_if.in_data  = {16'(img[1][r][x]), 16'(img[0][r][x])};
            guard = 0;
            took  = 1'b0;
            while (!took && guard < 200) begin
                @(negedge clock);
                took = tb_if.in_ready;
                @(posedge clock);
                #1;
                guard++;
            end
            tb_if.in_valid = 1'b0;
            if (!took) begin
                chk("in_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send_frame(input int m, input bit rv);
        model(m);
        send_pixels(m, H * IW, rv);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || tb_if.out_valid) && guard < 500) begin
            @(posedge clock);
            #1;
            guard++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        tb_if.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            tb_if.out_ready = bp ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    initial begin
        bit stalled;
        logic [C*W-1:0] held_data;
        logic held_last;
        exp_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n) stalled = 1'b0;
            else begin
                if (stalled) begin
                    chk("stall_valid", int'(tb_if.out_valid), 1);
                    chk("stall_data", int'(tb_if.out_data), int'(held_data));
                    chk("stall_last", int'(tb_if.out_last), int'(held_last));
                end
                if (tb_if.out_valid) chk("busy_out", int'(tb_if.busy), 1);
                if (tb_if.out_valid && tb_if.out_ready) begin
                    if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_ch0", int'(signed'(tb_if.out_data[15:0])), e.d0);
                        chk("out_ch1", int'(signed'(tb_if.out_data[31:16])), e.d1);
                        chk("out_last", int'(tb_if.out_last), int'(e.last));
                    end
                end
                if (tb_if.out_valid && !tb_if.out_ready) chk("stall_in_ready", int'(tb_if.in_ready), 0);
                stalled   = tb_if.out_valid && !tb_if.out_ready;
                held_data = tb_if.out_data;
                held_last = tb_if.out_last;
            end
        end
    end

    initial begin
        tb_if.in_valid = 1'b0;
        tb_if.in_data  = '0;
        tb_if.mode     = 1'b0;
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", int'(tb_if.in_ready), 0);
        chk("rst_out_valid", int'(tb_if.out_valid), 0);
        chk("rst_out_last", int'(tb_if.out_last), 0);
        chk("rst_busy", int'(tb_if.busy), 0);
        chk("rst_out_data", int'(tb_if.out_data), 0);
        reset_n = 1'b0;
        @(negedge clock);
        chk("rel_in_ready_pre", int'(tb_if.in_ready), 0);
        @(posedge clock);
        #1;
        chk("rel_in_ready", int'(tb_if.in_ready), 1);

        set_base();
        send_frame(0, 1'b0);
        send_frame(1, 1'b0);
        wait_drain();
        chk("idle_busy", int'(tb_if.busy), 0);

        rand_img();
        img[0][0][0] = -3; img[0][0][1] = -1; img[0][1][0] = -8; img[0][1][1] = -2;
        send_frame(0, 1'b0);
        img[0][0][0] = -1; img[0][0][1] = -2; img[0][1][0] = -2; img[0][1][1] = -2;
        send_frame(1, 1'b0);
        wait_drain();

        bp = 1'b1;
        set_base();
        send_frame(0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            rand_img();
            send_frame(int'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain();
        bp = 1'b0;

        rdy_fix = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        set_base();
        send_pixels(1, 6, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("abort_pending", int'(tb_if.out_valid), 1);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_out_valid", int'(tb_if.out_valid), 0);
        chk("abort_busy", int'(tb_if.busy), 0);
        chk("abort_in_ready", int'(tb_if.in_ready), 0);
        reset_n = 1'b0;
        rdy_fix = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        send_frame(0, 1'b0);
        wait_drain();

        for (int r = 0; r < H; r++)
            for (int x = 0; x < IW; x++) begin
                img[0][r][x] = r < 2 ? 32767 : -32768;
                img[1][r][x] = (x + r) % 2 != 0 ? 32767 : -32768;
            end
        send_frame(1, 1'b0);
        send_frame(0, 1'b0);
        wait_drain();
        chk("end_busy", int'(tb_if.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
